// File: rtl/seq_gen.sv
// Serial pattern generator: sends an 8-bit pattern MSB first, rep+1 times back to back,
// then pulses done for one cycle. Moore FSM; every output is decoded from registered state.
module seq_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] pattern,
    input  logic [3:0] rep,
    output logic       a,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] patt_q, patt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] rep_cnt_q, rep_cnt_d;

    logic last_bit;
    assign last_bit = (bit_cnt_q == 3'd0);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused code 2'b11 falls into default and returns to IDLE.
    // NOTE: state_d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start ? SEND : IDLE;
            SEND:    state_d = (last_bit && (rep_cnt_q == 4'd0)) ? DONE : SEND;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        a     = 1'b1;
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            SEND: begin
                a     = shreg_q[7];
                valid = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next-state: capture on accepted start, shift/reload while sending.
    always_comb begin
        shreg_d   = shreg_q;
        patt_d    = patt_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    patt_d    = pattern;
                    shreg_d   = pattern;
                    rep_cnt_d = rep;
                    bit_cnt_d = 3'd7;
                end
            end
            SEND: begin
                if (!last_bit) begin
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                end else if (rep_cnt_q != 4'd0) begin
                    // Reload with no gap cycle between repetitions.
                    shreg_d   = patt_q;
                    bit_cnt_d = 3'd7;
                    rep_cnt_d = rep_cnt_q - 4'd1;
                end else begin
                    shreg_d = {shreg_q[6:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q   <= 8'h00;
            patt_q    <= 8'h00;
            bit_cnt_q <= 3'd0;
            rep_cnt_q <= 4'd0;
        end else begin
            shreg_q   <= shreg_d;
            patt_q    <= patt_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen; outputs are checked 1 time unit after each
// rising edge, as the vector {a, valid, busy, done}.
module tb_seq_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] rep;
    logic       a, valid, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    seq_gen dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .rep     (rep),
        .a       (a),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] OUT_IDLE = 4'b1000;
    localparam logic [3:0] OUT_DONE = 4'b1011;

    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {a, valid, busy, done};
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: {a,valid,busy,done} got %b expected %b (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One transmission: start is sampled at the first edge; every SEND cycle, the DONE cycle
    // and the following IDLE cycle are checked. poke re-pulses start (with 8'hFF) mid-send,
    // hold keeps start high throughout, disturb scrambles pattern/rep after acceptance.
    task automatic xmit(input string tag, input logic [7:0] pat, input logic [3:0] r,
                        input bit poke, input bit hold, input bit disturb);
        int nbits;
        int idx;
        pattern = pat;
        rep     = r;
        start   = 1'b1;
        next_cycle();
        if (!hold) start = 1'b0;
        nbits = 8 * (int'(r) + 1);
        for (int i = 0; i < nbits; i++) begin
            idx = 7 - (i % 8);
            check($sformatf("%s bit%0d", tag, i), {pat[idx], 3'b110});
            if (disturb) begin
                pattern = ~pat;
                rep     = ~r;
            end
            if (poke) begin
                start   = (i == 3);
                pattern = 8'hFF;
            end
            next_cycle();
        end
        check({tag, " done"}, OUT_DONE);
        next_cycle();
        check({tag, " idle"}, OUT_IDLE);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        pattern = 8'h00;
        rep     = 4'h0;
        #1;
        check("reset asserted", OUT_IDLE);
        #11 reset = 1'b0;
        #1;
        check("reset released", OUT_IDLE);
        next_cycle();
        next_cycle();
        check("idle no start", OUT_IDLE);

        xmit("p01_r0", 8'h01, 4'h0, 1'b0, 1'b0, 1'b0);
        xmit("pA5_r2", 8'hA5, 4'h2, 1'b0, 1'b0, 1'b1);
        xmit("p3C_poke", 8'h3C, 4'h0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        next_cycle();
        check("after poke idle", OUT_IDLE);

        // Held start: DONE plus exactly one IDLE cycle between transmissions.
        xmit("p81_hold1", 8'h81, 4'h0, 1'b0, 1'b1, 1'b0);
        xmit("p81_hold2", 8'h81, 4'h0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        next_cycle();
        check("hold released idle", OUT_IDLE);

        // Maximum repeat count: 128 contiguous bits.
        xmit("p5A_r15", 8'h5A, 4'hF, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset during the 4th bit of 8'hF0.
        pattern = 8'hF0;
        rep     = 4'h0;
        start   = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < 3; i++) next_cycle();
        check("pF0 bit3", 4'b1110);
        #2 reset = 1'b1;
        #1;
        check("async reset immediate", OUT_IDLE);
        @(posedge clk);
        #1;
        check("reset held", OUT_IDLE);
        #3 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            check($sformatf("post-abort idle %0d", i), OUT_IDLE);
        end
        xmit("p0F_after_reset", 8'h0F, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset; forces the reset state immediately, independent of clk.
REQ-003 SHALL have port: start  input  1  request to begin a transmission; sampled on rising clk.
REQ-004 SHALL have port: pattern  input  8  bit pattern to transmit, MSB first; captured on accepted start.
REQ-005 SHALL have port: rep  input  4  repeat count; pattern is sent rep+1 times (1..16); captured on accepted start.
REQ-006 SHALL have port: a  output  1  serial bit stream; idle level 1.
REQ-007 SHALL have port: valid  output  1  high on every cycle in which a carries a pattern bit.
REQ-008 SHALL have port: busy  output  1  high from the cycle after an accepted start through the done cycle inclusive.
REQ-009 SHALL have port: done  output  1  single-cycle pulse marking end of transmission.

Function
REQ-010 SHALL implement a Moore FSM with states IDLE, SEND, DONE; all outputs decoded from registered state only, no combinational path from inputs to outputs.
REQ-011 SHALL hold internal registers: shreg[7:0], patt_q[7:0], bit_cnt[2:0], rep_cnt[3:0].
REQ-012 IDLE: a=1, valid=0, busy=0, done=0; start=1 at edge k SHALL load patt_q=pattern, shreg=pattern, rep_cnt=rep, bit_cnt=7, next state SEND.
REQ-013 IDLE with start=0 SHALL remain in IDLE.
REQ-014 SEND: a=shreg[7], valid=1, busy=1, done=0; each edge shifts shreg left by one (LSB filled 0) and decrements bit_cnt.
REQ-015 SEND with bit_cnt=0 and rep_cnt!=0 SHALL reload shreg=patt_q, set bit_cnt=7, decrement rep_cnt, remain in SEND with no gap cycle.
REQ-016 SEND with bit_cnt=0 and rep_cnt=0 SHALL go to DONE.
REQ-017 DONE: a=1, valid=0, busy=1, done=1 for exactly one cycle; unconditional next state IDLE.
REQ-018 Latency: start sampled at edge k SHALL produce first bit (pattern[7]) during cycle k+1; SEND lasts exactly 8*(rep+1) cycles; done asserted in cycle k+1+8*(rep+1).
REQ-019 start SHALL be ignored in SEND and DONE; no queuing; start held high through DONE is accepted on the first IDLE cycle edge.
REQ-020 Changes on pattern or rep after acceptance SHALL NOT affect the transmission in progress.
REQ-021 Counters SHALL NOT wrap: bit_cnt and rep_cnt are only decremented when nonzero per REQ-014..016.
REQ-022 State encoding SHALL cover unused codes: any illegal state SHALL return to IDLE on the next edge with IDLE outputs.

Reset
REQ-023 reset=1 SHALL asynchronously force state=IDLE, shreg=0, patt_q=0, bit_cnt=0, rep_cnt=0.
REQ-024 During and immediately after reset outputs SHALL be a=1, valid=0, busy=0, done=0.
REQ-025 Reset asserted mid-SEND SHALL abort the transmission with no done pulse; first start after reset release begins a fresh transmission.

Verification
REQ-026 pattern=8'h01, rep=0, start 1-cycle pulse at edge k -> a=0,0,0,0,0,0,0,1 in cycles k+1..k+8, valid=1 for those 8 cycles, done=1 only in cycle k+9, busy=1 cycles k+1..k+9.
REQ-027 pattern=8'hA5, rep=2 -> 24 contiguous valid cycles carrying 10100101 three times, no gap, single done pulse in cycle k+25.
REQ-028 start re-pulsed with pattern=8'hFF during SEND of 8'h3C -> output remains 00111100, no restart, single done.
REQ-029 start held high continuously, pattern=8'h81, rep=0 -> transmissions separated by exactly DONE and one IDLE cycle (a=1, valid=0 for 2 cycles).
REQ-030 reset asserted asynchronously (between edges) in 4th bit of 8'hF0 -> a=1, valid=0, busy=0 immediately; no done; subsequent start with 8'h0F transmits 00001111 correctly.
